pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline stage register. It is the successor to the fixed-field MEM/WB latch and is usable at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque DATA_W-bit payload (control bits, ALU result, memory data, destination register, instruction type/number tags) under a valid/ready handshake. A 2-entry skid buffer gives full throughput while keeping `in_ready` free of any combinational path from `out_ready`. A synchronous flush input kills in-flight entries on branch or exception.

---
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_pipe_stage_reg.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake with a 2-entry skid buffer and synchronous flush.
// Optional statistics counters are built only when PIPE_STAGE_REG_STATS_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 79,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Encoding is the valid-bit pair {skid_valid, out_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] skid_data;
  logic              skid_valid;
  logic              accept, take;
  logic              load_main_in, load_main_skid, load_skid;

  assign out_valid  = (state != EMPTY);
  assign skid_valid = (state == FULL);
  assign in_ready   = ~skid_valid;
  assign accept     = in_valid & in_ready;
  assign take       = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && take) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (take) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over everything; data registers are left untouched.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_in)
        out_data <= in_data;
      else if (load_main_skid)
        out_data <= skid_data;
      if (load_skid)
        skid_data <= in_data;
    end
  end

`ifdef PIPE_STAGE_REG_STATS_EN
  logic stall_evt, drop_evt;

  assign stall_evt = out_valid & ~out_ready;
  // A flush only counts if it actually destroys a held entry; a main entry taken this cycle is not lost.
  assign drop_evt  = flush & (skid_valid | (out_valid & ~out_ready));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (drop_evt && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based model of the stage contents.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 79;
  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = 15;
`ifdef PIPE_STAGE_REG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, flush;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  int unsigned   stall_m = 0;
  int unsigned   flush_m = 0;

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic bit exp_ov();
    return mq.size() > 0;
  endfunction
  function automatic bit exp_ir();
    return mq.size() < 2;
  endfunction
  function automatic logic [DW-1:0] exp_od();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction
  function automatic logic [CW-1:0] exp_stall();
    return STATS ? CW'(stall_m) : '0;
  endfunction
  function automatic logic [CW-1:0] exp_flush();
    return STATS ? CW'(flush_m) : '0;
  endfunction

  // Advance one clock edge, updating the model from the inputs presented this cycle.
  task automatic tick();
    bit acc, tk;
    acc = in_valid && (mq.size() < 2);
    tk  = (mq.size() > 0) && out_ready;
    if ((mq.size() > 0) && !out_ready && stall_m < CMAX) stall_m++;
    if (flush) begin
      if ((mq.size() == 2 || (mq.size() == 1 && !out_ready)) && flush_m < CMAX) flush_m++;
      mq.delete();
    end else begin
      if (tk) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b exp 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin
        errors++; $display("FAIL stream_out[%0d] got v=%0b d=%h exp v=1 d=%h", i, out_valid, out_data, DW'(i)); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_skid();
    bit          iv[8]  = '{1, 1, 1, 1, 1, 0, 0, 0};
    logic [7:0]  id[8]  = '{8'hA, 8'hB, 8'hC, 8'hC, 8'hC, 8'h0, 8'h0, 8'h0};
    bit          ord[8] = '{1, 0, 0, 1, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      in_valid = iv[i]; in_data = DW'(id[i]); out_ready = ord[i];
      tick();
      checks++; if (out_valid !== exp_ov() || in_ready !== exp_ir()) begin
        errors++; $display("FAIL skid_flags[%0d] got v=%0b r=%0b exp v=%0b r=%0b", i, out_valid, in_ready, exp_ov(), exp_ir()); end
      if (exp_ov()) begin
        checks++; if (out_data !== exp_od()) begin errors++; $display("FAIL skid_data[%0d] got %h exp %h", i, out_data, exp_od()); end
      end
    end
    checks++; if (stall_cnt !== exp_stall()) begin errors++; $display("FAIL skid_stall_cnt got %0d exp %0d", stall_cnt, exp_stall()); end
  endtask

  task automatic test_flush();
    logic [CW-1:0] f0;
    f0 = exp_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = DW'(8'h11); tick();
    in_data = DW'(8'h22); tick();
    checks++; if (in_ready !== 1'b0 || out_data !== DW'(8'h11)) begin
      errors++; $display("FAIL flush_setup got r=%0b d=%h exp r=0 d=11", in_ready, out_data); end
    in_data = DW'(8'h33); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_empty got v=%0b r=%0b exp v=0 r=1", out_valid, in_ready); end
    checks++; if (flush_cnt !== exp_flush() || (STATS && flush_cnt !== f0 + 1'b1)) begin
      errors++; $display("FAIL flush_cnt got %0d exp %0d", flush_cnt, exp_flush()); end
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got v=%0b d=%h exp v=0", out_valid, out_data); end
    end
  endtask

  task automatic test_flush_cases();
    // Flush while empty: nothing dropped.
    in_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || flush_cnt !== exp_flush()) begin
      errors++; $display("FAIL flush_on_empty got v=%0b cnt=%0d exp v=0 cnt=%0d", out_valid, flush_cnt, exp_flush()); end
    // ONE with take and flush: main entry delivered, not counted.
    in_valid = 1'b1; in_data = DW'(8'h44); out_ready = 1'b1; tick();
    in_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || flush_cnt !== exp_flush()) begin
      errors++; $display("FAIL flush_take_one got v=%0b cnt=%0d exp v=0 cnt=%0d", out_valid, flush_cnt, exp_flush()); end
    // FULL with take and flush: skid lost, counted.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = DW'(8'h55); tick();
    in_data = DW'(8'h66); tick();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || flush_cnt !== exp_flush()) begin
      errors++; $display("FAIL flush_take_full got v=%0b cnt=%0d exp v=0 cnt=%0d", out_valid, flush_cnt, exp_flush()); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(8'h77); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (stall_cnt !== exp_stall()) begin
        errors++; $display("FAIL sat_stall[%0d] got %0d exp %0d", i, stall_cnt, exp_stall()); end
    end
    checks++; if (stall_cnt !== (STATS ? CW'(CMAX) : CW'(0))) begin
      errors++; $display("FAIL sat_final got %0d exp %0d", stall_cnt, STATS ? CMAX : 0); end
    checks++; if (out_valid !== 1'b1 || out_data !== DW'(8'h77)) begin
      errors++; $display("FAIL sat_hold got v=%0b d=%h exp v=1 d=77", out_valid, out_data); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = DW'(8'h88); tick();
    in_data = DW'(8'h99); tick();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL areset_flags got v=%0b r=%0b exp v=0 r=1", out_valid, in_ready); end
    checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++; $display("FAIL areset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    mq.delete(); stall_m = 0; flush_m = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_after got v=%0b exp 0", out_valid); end
  endtask

  task automatic test_random();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = DW'({$urandom, $urandom, $urandom});
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      acc = in_valid && exp_ir();
      tick();
      if (acc || flush) in_valid = 1'b0;
      flush = 1'b0;
      checks++; if (out_valid !== exp_ov() || in_ready !== exp_ir()) begin
        errors++; $display("FAIL rand_flags[%0d] got v=%0b r=%0b exp v=%0b r=%0b", i, out_valid, in_ready, exp_ov(), exp_ir()); end
      if (exp_ov()) begin
        checks++; if (out_data !== exp_od()) begin errors++; $display("FAIL rand_data[%0d] got %h exp %h", i, out_data, exp_od()); end
      end
      checks++; if (stall_cnt !== exp_stall() || flush_cnt !== exp_flush()) begin
        errors++; $display("FAIL rand_cnt[%0d] got %0d/%0d exp %0d/%0d", i, stall_cnt, flush_cnt, exp_stall(), exp_flush()); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_flush_cases();
    test_saturation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
